// File: rtl/switch_led_ctrl.sv
// ============================================================================
//  switch_led_ctrl
//  Sequences a switch bank onto an LED bank in four button-selected modes:
//  PASS, COUNT, SHIFT and HOLD. Build option SHIFT_BOUNCE_EN makes SHIFT
//  bounce a pattern between the ends of the bank instead of rotating it.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module switch_led_ctrl #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_DIV        = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  logic             btn_mode,
    output logic [WIDTH-1:0] led,
    output logic [1:0]       mode
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES);
    localparam int c_TW = $clog2(TICK_DIV);
    localparam logic [c_DW-1:0]  c_DMAX = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_TW-1:0]  c_TMAX = c_TW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {
        S_PASS  = 2'd0,
        S_COUNT = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    logic [WIDTH-1:0] r_sw_meta;
    logic [WIDTH-1:0] r_sw_s;
    logic             r_btn_meta;
    logic             r_btn_s;
    logic             r_btn_db;
    logic [c_DW-1:0]  r_dcnt;
    logic [c_TW-1:0]  r_tcnt;
    state_t           r_state;
    logic [WIDTH-1:0] r_led;

    logic             w_diff;
    logic             w_flip;
    logic             w_step;
    logic             w_tick;
    state_t           w_next_state;
    logic [WIDTH-1:0] w_shift_entry;

    // Two-flop synchronisers for the asynchronous board inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_sw_meta  <= switch;
            r_sw_s     <= r_sw_meta;
            r_btn_meta <= btn_mode;
            r_btn_s    <= r_btn_meta;
        end
    end

    assign w_diff = (r_btn_s != r_btn_db);
    assign w_flip = w_diff && (r_dcnt == c_DMAX);
    assign w_step = w_flip && !r_btn_db;
    assign w_tick = (r_tcnt == c_TMAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_db <= 1'b0;
            r_dcnt   <= '0;
        end else begin
            if (w_flip) begin
                r_btn_db <= ~r_btn_db;
            end
            if (!w_diff || w_flip) begin
                r_dcnt <= '0;
            end else begin
                r_dcnt <= r_dcnt + c_DW'(1);
            end
        end
    end

    // A step restarts the tick phase so a fresh mode gets a full tick period
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_step || w_tick) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + c_TW'(1);
        end
    end

    always_comb begin
        w_next_state = S_PASS;
        case (r_state)
            S_PASS:  w_next_state = S_COUNT;
            S_COUNT: w_next_state = S_SHIFT;
            S_SHIFT: w_next_state = S_HOLD;
            S_HOLD:  w_next_state = S_PASS;
            default: w_next_state = S_PASS;
        endcase
    end

    // An all-zero seed would leave nothing visible to shift
    assign w_shift_entry = (r_sw_s == '0) ? c_ONE : r_sw_s;

`ifdef SHIFT_BOUNCE_EN
    logic             r_dir;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;

    assign w_shl = {r_led[WIDTH-2:0], 1'b0};
    assign w_shr = {1'b0, r_led[WIDTH-1:1]};
`endif

    // Mode FSM and LED register; a step takes priority over a same-cycle tick
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PASS;
            r_led   <= '0;
`ifdef SHIFT_BOUNCE_EN
            r_dir   <= 1'b0;
`endif
        end else if (w_step) begin
            r_state <= w_next_state;
            case (w_next_state)
                S_COUNT: r_led <= r_sw_s;
                S_SHIFT: begin
                    r_led <= w_shift_entry;
`ifdef SHIFT_BOUNCE_EN
                    r_dir <= 1'b0;
`endif
                end
                S_HOLD:  r_led <= r_led;
                default: r_led <= r_sw_s;
            endcase
        end else begin
            case (r_state)
                S_PASS: r_led <= r_sw_s;
                S_COUNT: begin
                    if (w_tick) begin
                        r_led <= r_led + c_ONE;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
`ifdef SHIFT_BOUNCE_EN
                        if (!r_dir) begin
                            r_led <= w_shl;
                            if (w_shl[WIDTH-1]) begin
                                r_dir <= 1'b1;
                            end
                        end else begin
                            r_led <= w_shr;
                            if (w_shr[0]) begin
                                r_dir <= 1'b0;
                            end
                        end
`else
                        r_led <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
`endif
                    end
                end
                default: r_led <= r_led;
            endcase
        end
    end

    assign led  = r_led;
    assign mode = r_state;

endmodule

`default_nettype wire

// File: tb/tb_switch_led_ctrl.sv
// ============================================================================
//  tb_switch_led_ctrl
//  Scoreboard bench: driver pushes reference-model predictions, monitor checks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_led_ctrl;

    localparam int W  = 6;
    localparam int DB = 4;
    localparam int TD = 3;

    logic         clk;
    logic         rst;
    logic [W-1:0] switch;
    logic         btn_mode;
    logic [W-1:0] led;
    logic [1:0]   mode;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    // Reference model state
    int m_sw_pipe[2];
    int m_btn_pipe[2];
    int m_db, m_run, m_tcnt, m_mode, m_led, m_dir;

    switch_led_ctrl #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .switch(switch),
        .btn_mode(btn_mode),
        .led(led),
        .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Advance the reference model by one clock edge with the given inputs
    task automatic model_step(input logic r, input logic [W-1:0] sw, input logic b);
        int  s_cur, b_cur;
        bit  stepped, ticked;
        if (r) begin
            m_sw_pipe  = '{0, 0};
            m_btn_pipe = '{0, 0};
            m_db = 0; m_run = 0; m_tcnt = 0; m_mode = 0; m_led = 0; m_dir = 0;
            return;
        end
        s_cur   = m_sw_pipe[1];
        b_cur   = m_btn_pipe[1];
        stepped = 0;
        if (b_cur != m_db) begin
            m_run++;
            if (m_run == DB) begin
                m_db    = b_cur;
                m_run   = 0;
                stepped = (b_cur == 1);
            end
        end else begin
            m_run = 0;
        end
        ticked = (m_tcnt == TD - 1);
        m_tcnt = (stepped || ticked) ? 0 : m_tcnt + 1;
        if (stepped) begin
            m_mode = (m_mode + 1) % 4;
            if (m_mode == 1 || m_mode == 0) m_led = s_cur;
            else if (m_mode == 2) begin
                m_led = (s_cur == 0) ? 1 : s_cur;
                m_dir = 0;
            end
        end else if (m_mode == 0) begin
            m_led = s_cur;
        end else if (ticked && m_mode == 1) begin
            m_led = (m_led + 1) % 64;
        end else if (ticked && m_mode == 2) begin
`ifdef SHIFT_BOUNCE_EN
            if (m_dir == 0) begin
                m_led = (m_led * 2) % 64;
                if (m_led >= 32) m_dir = 1;
            end else begin
                m_led = m_led / 2;
                if (m_led % 2 == 1) m_dir = 0;
            end
`else
            m_led = ((m_led * 2) % 64) + (m_led / 32);
`endif
        end
        m_sw_pipe[1]  = m_sw_pipe[0];
        m_sw_pipe[0]  = int'(sw);
        m_btn_pipe[1] = m_btn_pipe[0];
        m_btn_pipe[0] = int'(b);
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic drive(input logic r, input logic [W-1:0] sw, input logic b);
        rst      = r;
        switch   = sw;
        btn_mode = b;
        model_step(r, sw, b);
        exp_q.push_back({W'(m_led), 2'(m_mode)});
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic press_release(input logic [W-1:0] sw);
        repeat (8) drive(1'b0, sw, 1'b1);
        repeat (8) drive(1'b0, sw, 1'b0);
    endtask

    // Monitor: the registered outputs are valid every cycle once driving starts
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({led, mode} !== e) begin
                    n_errors++;
                    $display("FAIL scoreboard: led=%0h mode=%0d expected led=%0h mode=%0d at %0t",
                             led, mode, e[7:2], e[1:0], $time);
                end
            end
        end
    end

    initial begin
        int hold_val;
        int lvl, run_left;
        logic [W-1:0] sw_r;
        rst = 1'b1; switch = '0; btn_mode = 1'b0;
        @(negedge clk);

        // Reset with active-looking inputs
        repeat (2) drive(1'b1, 6'h2A, 1'b1);
        chk("reset_led", int'(led), 0);
        chk("reset_mode", int'(mode), 0);
        drive(1'b0, 6'h2A, 1'b1);
        chk("post_reset_led", int'(led), 0);
        chk("post_reset_mode", int'(mode), 0);

        // PASS latency
        repeat (4) drive(1'b0, 6'h00, 1'b0);
        drive(1'b0, 6'h15, 1'b0);
        chk("pass_edge_n", int'(led), 0);
        drive(1'b0, 6'h15, 1'b0);
        chk("pass_edge_n1", int'(led), 0);
        drive(1'b0, 6'h15, 1'b0);
        chk("pass_edge_n2", int'(led), 'h15);

        // Debounce: short glitch rejected, long press steps exactly once
        repeat (3) drive(1'b0, 6'h15, 1'b1);
        repeat (8) drive(1'b0, 6'h15, 1'b0);
        chk("glitch_mode", int'(mode), 0);
        repeat (10) drive(1'b0, 6'h15, 1'b1);
        chk("press1_mode", int'(mode), 1);
        repeat (8) drive(1'b0, 6'h15, 1'b0);
        chk("release_mode", int'(mode), 1);
        press_release(6'h15);
        chk("press2_mode", int'(mode), 2);
        press_release(6'h15);
        press_release(6'h15);
        chk("wrap_mode", int'(mode), 0);

        // COUNT wrap from 3E
        repeat (4) drive(1'b0, 6'h3E, 1'b0);
        press_release(6'h3E);
        chk("count_mode", int'(mode), 1);
        repeat (12) drive(1'b0, 6'h3E, 1'b0);

        // SHIFT from all-zero switches, then HOLD
        repeat (4) drive(1'b0, 6'h00, 1'b0);
        press_release(6'h00);
        chk("shift_mode", int'(mode), 2);
        repeat (24) drive(1'b0, 6'h00, 1'b0);
        press_release(6'h00);
        chk("hold_mode", int'(mode), 3);
        hold_val = m_led;
        for (int i = 0; i < 20; i++) drive(1'b0, (i % 2) ? 6'h3F : 6'h00, 1'b0);
        chk("hold_led", int'(led), hold_val);
        press_release(6'h2A);
        repeat (4) drive(1'b0, 6'h2A, 1'b0);
        chk("back_pass_mode", int'(mode), 0);
        chk("back_pass_led", int'(led), 'h2A);

        // Step coinciding with a tick in COUNT
        press_release(6'h0C);
        for (int i = 0; i < 10 && m_tcnt != 0; i++) drive(1'b0, 6'h0C, 1'b0);
        repeat (6) drive(1'b0, 6'h0C, 1'b1);
        chk("collide_mode", int'(mode), 2);
        chk("collide_led", int'(led), 'h0C);
        repeat (8) drive(1'b0, 6'h0C, 1'b0);

        // Reset in the middle of a debounce
        repeat (4) drive(1'b0, 6'h0C, 1'b1);
        drive(1'b1, 6'h0C, 1'b1);
        repeat (3) drive(1'b0, 6'h0C, 1'b1);
        chk("mid_db_rst_mode", int'(mode), 0);
        repeat (5) drive(1'b0, 6'h0C, 1'b1);
        chk("new_press_mode", int'(mode), 1);
        repeat (8) drive(1'b0, 6'h0C, 1'b0);

        // Randomised traffic
        lvl = 0; run_left = 5; sw_r = 6'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) sw_r = W'($urandom);
            if (run_left == 0) begin
                lvl = 1 - lvl;
                run_left = $urandom_range(1, 12);
            end
            run_left--;
            drive(($urandom_range(0, 499) == 0), sw_r, lvl[0]);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
